// File: rtl/sa_ctrl_pkg.sv
// sa_ctrl_pkg: shared types and memory-map helpers for the systolic-array
// control sequencer.
package sa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_W = 3'd1,
        ST_LOAD_I = 3'd2,
        ST_WAIT_V = 3'd3,
        ST_STORE  = 3'd4,
        ST_DONE   = 3'd5
    } sa_state_e;

    // Region offsets inside one tile, in units of phase length (N*N words).
    localparam int REGION_W    = 0;
    localparam int REGION_I    = 1;
    localparam int REGION_O    = 2;
    localparam int TILE_STRIDE = 3;

    function automatic int phase_len(input int n);
        return n * n;
    endfunction

endpackage

// File: rtl/sa_ctrl_fsm_if.sv
// sa_ctrl_fsm_if: memory / array datapath side of the sequencer.
// master = sequencer, slave = memory and systolic array.
interface sa_ctrl_fsm_if #(
    parameter int ADDR_W = 10
);
    logic              load_weights;
    logic              load_inputs;
    logic              store_outputs;
    logic              ren;
    logic              wen;
    logic [ADDR_W-1:0] address_o;
    logic              valid_out;

    modport master (
        output load_weights,
        output load_inputs,
        output store_outputs,
        output ren,
        output wen,
        output address_o,
        input  valid_out
    );

    modport slave (
        input  load_weights,
        input  load_inputs,
        input  store_outputs,
        input  ren,
        input  wen,
        input  address_o,
        output valid_out
    );
endinterface

// File: rtl/sa_ctrl_addr_gen.sv
// sa_ctrl_addr_gen: element counter, per-tile base accumulator and the
// registered memory address. The address register is loaded from the
// *next* state and counter values so it lines up with the registered
// control outputs of the sequencer; outside the streaming phases it holds.
module sa_ctrl_addr_gen
    import sa_ctrl_pkg::*;
#(
    parameter int N      = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  sa_state_e         state_d,
    input  logic              job_clr,
    input  logic              tile_adv,
    input  logic              elem_clr,
    input  logic              elem_adv,
    output logic              elem_last,
    output logic [ADDR_W-1:0] address
);
    localparam int PH     = phase_len(N);
    localparam int ELEM_W = (PH > 1) ? $clog2(PH) : 1;

    localparam logic [ADDR_W-1:0] OFF_W    = ADDR_W'(REGION_W * PH);
    localparam logic [ADDR_W-1:0] OFF_I    = ADDR_W'(REGION_I * PH);
    localparam logic [ADDR_W-1:0] OFF_O    = ADDR_W'(REGION_O * PH);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(TILE_STRIDE * PH);
    localparam logic [ELEM_W-1:0] ELEM_MAX = ELEM_W'(PH - 1);

    logic [ELEM_W-1:0] elem_q, elem_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_d;

    assign elem_last = (elem_q == ELEM_MAX);

    // Counter update: job clear, tile advance, phase clear or element step
    always_comb begin
        elem_d = elem_q;
        base_d = base_q;
        if (job_clr) begin
            elem_d = '0;
            base_d = '0;
        end else if (tile_adv) begin
            elem_d = '0;
            base_d = base_q + STRIDE;
        end else if (elem_clr) begin
            elem_d = '0;
        end else if (elem_adv) begin
            elem_d = elem_q + ELEM_W'(1);
        end
    end

    // Address mux from the upcoming state; modulo 2^ADDR_W wrap is intended
    always_comb begin
        addr_d = address;
        case (state_d)
            ST_LOAD_W: addr_d = base_d + OFF_W + ADDR_W'(elem_d);
            ST_LOAD_I: addr_d = base_d + OFF_I + ADDR_W'(elem_d);
            ST_STORE:  addr_d = base_d + OFF_O + ADDR_W'(elem_d);
            default:   addr_d = address;
        endcase
    end

    // Counter and address registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            elem_q  <= '0;
            base_q  <= '0;
            address <= '0;
        end else begin
            elem_q  <= elem_d;
            base_q  <= base_d;
            address <= addr_d;
        end
    end

endmodule

// File: rtl/sa_ctrl_fsm.sv
// sa_ctrl_fsm: multi-tile control sequencer for the N x N systolic array.
// Per tile: N*N weight reads (skipped for tiles >= 1 when reusing weights),
// N*N input reads, wait for valid_out, N*N output writes.
// Optional WAIT_V watchdog: define SA_CTRL_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for start; captures num_tiles / reuse_weights
// LOAD_W  | streaming weight reads for the current tile
// LOAD_I  | streaming input reads for the current tile
// WAIT_V  | waiting for the array's valid_out (watchdog if enabled)
// STORE   | streaming output writes for the current tile
// DONE    | one-cycle job-complete pulse
module sa_ctrl_fsm
    import sa_ctrl_pkg::*;
#(
    parameter int N       = 4,
    parameter int ADDR_W  = 10,
    parameter int TILE_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              reuse_weights,
    sa_ctrl_fsm_if.master     mem,
    output logic              busy,
    output logic              done,
    output logic              error
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("sa_ctrl_fsm: TIMEOUT must be at least 1");
    end

    sa_state_e         state_q, state_d;
    logic [TILE_W-1:0] tiles_q, tile_q;
    logic              reuse_q;
    logic              job_clr, tile_adv, elem_clr, elem_adv;
    logic              elem_last, last_tile, wdog_expired;
    logic              ld_w_q, ld_i_q, st_o_q, ren_q, wen_q, busy_q, done_q;
    logic [ADDR_W-1:0] addr_q;

    assign last_tile = (tile_q == (tiles_q - TILE_W'(1)));

    // Next-state and counter-strobe decode
    always_comb begin
        state_d  = state_q;
        job_clr  = 1'b0;
        tile_adv = 1'b0;
        elem_clr = 1'b0;
        elem_adv = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    job_clr = 1'b1;
                    state_d = (num_tiles == '0) ? ST_DONE : ST_LOAD_W;
                end
            end
            ST_LOAD_W: begin
                if (elem_last) begin
                    elem_clr = 1'b1;
                    state_d  = ST_LOAD_I;
                end else begin
                    elem_adv = 1'b1;
                end
            end
            ST_LOAD_I: begin
                if (elem_last) state_d  = ST_WAIT_V;
                else           elem_adv = 1'b1;
            end
            ST_WAIT_V: begin
                if (mem.valid_out) begin
                    elem_clr = 1'b1;
                    state_d  = ST_STORE;
                end else if (wdog_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_STORE: begin
                if (elem_last) begin
                    if (last_tile) begin
                        state_d = ST_DONE;
                    end else begin
                        tile_adv = 1'b1;
                        state_d  = reuse_q ? ST_LOAD_I : ST_LOAD_W;
                    end
                end else begin
                    elem_adv = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Job configuration captured on accepted start, and the tile index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tiles_q <= '0;
            reuse_q <= 1'b0;
            tile_q  <= '0;
        end else if (job_clr) begin
            tiles_q <= num_tiles;
            reuse_q <= reuse_weights;
            tile_q  <= '0;
        end else if (tile_adv) begin
            tile_q <= tile_q + TILE_W'(1);
        end
    end

    // Registered control outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ld_w_q <= 1'b0;
            ld_i_q <= 1'b0;
            st_o_q <= 1'b0;
            ren_q  <= 1'b0;
            wen_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            ld_w_q <= (state_d == ST_LOAD_W);
            ld_i_q <= (state_d == ST_LOAD_I);
            st_o_q <= (state_d == ST_STORE);
            ren_q  <= (state_d == ST_LOAD_W) || (state_d == ST_LOAD_I);
            wen_q  <= (state_d == ST_STORE);
            busy_q <= (state_d != ST_IDLE);
            done_q <= (state_d == ST_DONE);
        end
    end

    sa_ctrl_addr_gen #(
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .state_d   (state_d),
        .job_clr   (job_clr),
        .tile_adv  (tile_adv),
        .elem_clr  (elem_clr),
        .elem_adv  (elem_adv),
        .elem_last (elem_last),
        .address   (addr_q)
    );

`ifdef SA_CTRL_TIMEOUT_EN
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wdog_q;
    logic            error_q;

    assign wdog_expired = (wdog_q == '0);

    // Watchdog down-counter: reloaded on WAIT_V entry, counts down while waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wdog_q <= '0;
        else if ((state_d == ST_WAIT_V) && (state_q != ST_WAIT_V))
            wdog_q <= WD_LOAD;
        else if ((state_q == ST_WAIT_V) && !wdog_expired)
            wdog_q <= wdog_q - WD_W'(1);
    end

    // Sticky error: set when the watchdog abandons the job, cleared by next start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            error_q <= 1'b0;
        else if (job_clr)
            error_q <= 1'b0;
        else if ((state_q == ST_WAIT_V) && !mem.valid_out && wdog_expired)
            error_q <= 1'b1;
    end

    assign error = error_q;
`else
    assign wdog_expired = 1'b0;
    assign error        = 1'b0;
`endif

    assign mem.load_weights  = ld_w_q;
    assign mem.load_inputs   = ld_i_q;
    assign mem.store_outputs = st_o_q;
    assign mem.ren           = ren_q;
    assign mem.wen           = wen_q;
    assign mem.address_o     = addr_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_sa_ctrl_fsm.sv
// tb_sa_ctrl_fsm: randomized jobs against a tile-level reference model.
// Expected accesses, job length and error flag are queued at launch; a
// separate monitor pops and compares whenever the DUT presents them.
module tb_sa_ctrl_fsm;

    localparam int N         = 4;
    localparam int ADDR_W    = 10;
    localparam int TILE_W    = 8;
    localparam int TMO       = 10;
    localparam int PH        = N * N;
    localparam int AMOD      = 1 << ADDR_W;
    localparam int JOB_LIMIT = 5000;

    localparam logic [4:0] F_W = 5'b10010;   // {lw, li, so, ren, wen}
    localparam logic [4:0] F_I = 5'b01010;
    localparam logic [4:0] F_O = 5'b00101;

    typedef struct {
        logic [4:0] flags;
        int         addr;
    } txn_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic              reuse_weights;
    logic              busy, done, error;

    sa_ctrl_fsm_if #(.ADDR_W(ADDR_W)) mem_if ();

    sa_ctrl_fsm #(
        .N       (N),
        .ADDR_W  (ADDR_W),
        .TILE_W  (TILE_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .num_tiles     (num_tiles),
        .reuse_weights (reuse_weights),
        .mem           (mem_if),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    txn_t exp_q[$];
    int   busy_q[$];
    bit   err_q[$];
    int   delay_q[$];

    bit in_wait = 0;
    int wcnt = 0;
    int cur_d = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic int pick_delay();
        int r = $urandom_range(0, 7);
        if (r == 0) return TMO + 4;
        if (r == 1) return TMO - 1;
        return $urandom_range(0, 5);
    endfunction

    // Reference model: what a job of nt tiles must do, straight from the memory map
    function automatic void model_job(input int nt, input bit rw, input int fd);
        int cyc = 1;
        bit err = 0;
        delay_q.delete();
        for (int t = 0; t < nt; t++) begin
            int base = t * 3 * PH;
            int d = (fd >= 0) ? fd : pick_delay();
            if (t == 0 || !rw) begin
                for (int e = 0; e < PH; e++) exp_q.push_back('{F_W, (base + e) % AMOD});
                cyc += PH;
            end
            for (int e = 0; e < PH; e++) exp_q.push_back('{F_I, (base + PH + e) % AMOD});
            cyc += PH;
            delay_q.push_back(d);
`ifdef SA_CTRL_TIMEOUT_EN
            if (d >= TMO) begin
                cyc += TMO;
                err = 1;
                break;
            end
`endif
            cyc += d + 1;
            for (int e = 0; e < PH; e++) exp_q.push_back('{F_O, (base + 2 * PH + e) % AMOD});
            cyc += PH;
        end
        busy_q.push_back(cyc);
        err_q.push_back(err);
    endfunction

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    task automatic bound_fail(input string what);
        n_vec++;
        n_err++;
        $display("FAIL bound_%s: no progress within %0d cycles, expected completion", what, JOB_LIMIT);
        summary();
        $fatal(1, "bench stopped early");
    endtask

    // One cycle of stimulus: valid_out responder, start/config driver
    task automatic step(input bit launch, input int nt, input bit rw, input int fd,
                        output bit launched);
        @(negedge clk);
        launched = 0;
        if (busy && !mem_if.ren && !mem_if.wen && !done) begin
            if (!in_wait) begin
                in_wait = 1;
                wcnt    = 0;
                cur_d   = (delay_q.size() != 0) ? delay_q.pop_front() : 0;
            end
            mem_if.valid_out = (wcnt == cur_d);
            wcnt++;
        end else begin
            in_wait = 0;
            mem_if.valid_out = ($urandom_range(0, 4) == 0);
        end
        if (!busy && launch) begin
            start         = 1'b1;
            num_tiles     = TILE_W'(nt);
            reuse_weights = rw;
            model_job(nt, rw, fd);
            launched = 1;
        end else if (!busy) begin
            start         = 1'b0;
            num_tiles     = TILE_W'($urandom);
            reuse_weights = 1'($urandom);
        end else begin
            start         = ($urandom_range(0, 3) == 0);
            num_tiles     = TILE_W'($urandom);
            reuse_weights = 1'($urandom);
        end
    endtask

    task automatic launch_job(input int nt, input bit rw, input int fd);
        bit l = 0;
        int g = 0;
        while (!l && g < JOB_LIMIT) begin
            step(1, nt, rw, fd, l);
            g++;
        end
        if (!l) bound_fail("launch");
    endtask

    task automatic run_job(input int nt, input bit rw, input int fd);
        bit l;
        int g = 0;
        launch_job(nt, rw, fd);
        do begin
            step(0, 0, 0, -1, l);
            g++;
        end while (!done && g < JOB_LIMIT);
        if (!done) bound_fail("done");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ren"},   mem_if.ren, 0);
        chk({tag, "_wen"},   mem_if.wen, 0);
        chk({tag, "_addr"},  mem_if.address_o, 0);
        chk({tag, "_lw"},    mem_if.load_weights, 0);
        chk({tag, "_li"},    mem_if.load_inputs, 0);
        chk({tag, "_so"},    mem_if.store_outputs, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_error"}, error, 0);
    endtask

    task automatic reset_mid_store();
        bit l;
        int g = 0;
        launch_job(1, 0, 2);
        do begin
            step(0, 0, 0, -1, l);
            g++;
        end while (!(mem_if.wen && mem_if.address_o == ADDR_W'(2 * PH + 7)) && g < JOB_LIMIT);
        if (g >= JOB_LIMIT) bound_fail("store_elem7");
        #2 reset_n = 1'b0;
        #1 check_all_zero("reset_mid_store");
        exp_q.delete();
        busy_q.delete();
        err_q.delete();
        delay_q.delete();
        start            = 1'b0;
        mem_if.valid_out = 1'b0;
        in_wait          = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: pops expected accesses and job summaries as the DUT presents them
    bit   busy_cnt_en = 0;
    int   busy_cnt = 0;
    bit   after_done = 0;
    bit   last_err = 0;

    always @(negedge clk) begin : monitor
        logic [4:0] fl;
        txn_t       e;
        fl = {mem_if.load_weights, mem_if.load_inputs, mem_if.store_outputs,
              mem_if.ren, mem_if.wen};
        if (!reset_n) begin
            busy_cnt   = 0;
            after_done = 0;
        end else begin
            if (after_done) begin
                chk("busy_after_done", busy, 0);
                chk("done_pulse_width", done, 0);
                chk("error_sticky", error, last_err);
                after_done = 0;
            end
            if (busy && busy_cnt == 0) chk("error_cleared_on_start", error, 0);
            if (mem_if.ren || mem_if.wen) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_access: got addr %0d flags %b, expected no access",
                             mem_if.address_o, fl);
                end else begin
                    e = exp_q.pop_front();
                    chk("access_flags", fl, e.flags);
                    chk("access_addr", mem_if.address_o, e.addr);
                end
            end else begin
                chk("quiet_flags", fl, 0);
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (busy_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done=1, expected no job end");
                end else begin
                    chk("job_busy_cycles", busy_cnt, busy_q.pop_front());
                    last_err = err_q.pop_front();
                    chk("error_at_done", error, last_err);
                end
                chk("accesses_left_at_done", exp_q.size(), 0);
                busy_cnt   = 0;
                after_done = 1;
            end
        end
    end

    initial begin
        #(500000);
        n_err++;
        $display("FAIL sim_time_limit: got no end of test, expected finish");
        summary();
        $fatal(1, "bench stopped early");
    end

    initial begin
        reset_n          = 1'b0;
        start            = 1'b0;
        num_tiles        = '0;
        reuse_weights    = 1'b0;
        mem_if.valid_out = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_job(1, 0, 5);
        run_job(3, 1, -1);
        run_job(0, 0, -1);
        run_job(2, 0, -1);
        run_job(2, 0, TMO + 10);
        run_job(1, 0, 0);
        reset_mid_store();
        run_job(1, 0, -1);
        run_job(23, 1, 0);
        for (int j = 0; j < 40; j++)
            run_job($urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size() + busy_q.size(), 0);
        summary();
        $finish;
    end

endmodule
